// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : ID-stage branch compare with bounded operand wait and statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int WIDTH    = 32,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             pending_i,
    input  logic             kill_i,
    output logic             stall_o,
    output logic             resolved_o,
    output logic             taken_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    localparam int WC_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MAX_WAIT - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]      state;
    logic [WC_W-1:0] wait_cnt;
    logic            cmp_taken;
    logic            go_wait;
    logic            resolve;

    always_comb begin
        cmp_taken = 1'b0;
        case (mode_i)
            3'b000:  cmp_taken = (data1_i == data2_i);
            3'b001:  cmp_taken = (data1_i != data2_i);
            3'b010:  cmp_taken = ($signed(data1_i) <  $signed(data2_i));
            3'b011:  cmp_taken = ($signed(data1_i) >= $signed(data2_i));
            3'b100:  cmp_taken = (data1_i <  data2_i);
            3'b101:  cmp_taken = (data1_i >= data2_i);
            default: cmp_taken = 1'b0;
        endcase
    end

    // Resolution condition is identical in IDLE and WAIT; only the
    // pending/timeout bookkeeping differs between the two states.
    assign go_wait = (state == IDLE) & valid_i & pending_i & ~kill_i;
    assign resolve = valid_i & ~pending_i & ~kill_i;
    assign stall_o = ((state == WAIT) & ~kill_i) | go_wait;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            resolved_o   <= 1'b0;
            taken_o      <= 1'b0;
            timeout_o    <= 1'b0;
            branch_cnt_o <= '0;
            taken_cnt_o  <= '0;
        end else begin
            resolved_o <= resolve;
            taken_o    <= resolve & cmp_taken;

            if (resolve && (branch_cnt_o != {CNT_W{1'b1}})) begin
                branch_cnt_o <= branch_cnt_o + CNT_W'(1);
            end
            if (resolve && cmp_taken && (taken_cnt_o != {CNT_W{1'b1}})) begin
                taken_cnt_o <= taken_cnt_o + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (go_wait) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (kill_i || !valid_i || !pending_i) begin
                        state <= IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= IDLE;
                        timeout_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Randomised and directed checks of branch_resolve_unit vs. a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    logic        pending = 1'b0;
    logic        kill = 1'b0;

    logic        stall_a, res_a, tkn_a, to_a;
    logic [15:0] bc_a, tc_a;
    logic        stall_b, res_b, tkn_b, to_b;
    logic [1:0]  bc_b, tc_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.WIDTH(32), .CNT_W(16), .MAX_WAIT(MAX_WAIT)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .mode_i(mode),
        .data1_i(d1), .data2_i(d2), .pending_i(pending), .kill_i(kill),
        .stall_o(stall_a), .resolved_o(res_a), .taken_o(tkn_a),
        .timeout_o(to_a), .branch_cnt_o(bc_a), .taken_cnt_o(tc_a)
    );

    branch_resolve_unit #(.WIDTH(32), .CNT_W(2), .MAX_WAIT(MAX_WAIT)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .mode_i(mode),
        .data1_i(d1), .data2_i(d2), .pending_i(pending), .kill_i(kill),
        .stall_o(stall_b), .resolved_o(res_b), .taken_o(tkn_b),
        .timeout_o(to_b), .branch_cnt_o(bc_b), .taken_cnt_o(tc_b)
    );

    // Reference state: are we waiting, how many cycles waited, plus outputs
    bit m_waiting = 0;
    int m_waited  = 0;
    bit m_res = 0, m_tkn = 0, m_to = 0;
    int m_bc = 0, m_tc = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_taken(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (m)
            3'd0: return sa == sb;
            3'd1: return sa != sb;
            3'd2: return sa <  sb;
            3'd3: return sa >= sb;
            3'd4: return ua <  ub;
            3'd5: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // One clock: apply inputs, check stall, advance model, check registered outputs.
    task automatic cycle(input bit r, input bit v, input logic [2:0] m,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit p, input bit k);
        bit exp_stall;
        bit do_res;
        rst = r; valid = v; mode = m; d1 = a; d2 = b; pending = p; kill = k;
        #1;
        exp_stall = m_waiting ? !k : (v && p && !k);
        if (!r) begin
            check_val("stall_a", {31'b0, stall_a}, {31'b0, exp_stall});
            check_val("stall_b", {31'b0, stall_b}, {31'b0, exp_stall});
        end

        do_res = 0;
        if (r) begin
            m_waiting = 0; m_waited = 0; m_to = 0; m_bc = 0; m_tc = 0;
        end else if (!m_waiting) begin
            if (v && !k && p) begin
                m_waiting = 1; m_waited = 0;
            end else if (v && !k) begin
                do_res = 1;
            end
        end else begin
            if (k || !v) begin
                m_waiting = 0;
            end else if (!p) begin
                do_res = 1; m_waiting = 0;
            end else if (m_waited + 1 >= MAX_WAIT) begin
                m_waiting = 0; m_to = 1;
            end else begin
                m_waited++;
            end
        end
        m_res = do_res;
        m_tkn = do_res && ref_taken(m, a, b);
        if (do_res) begin
            m_bc++;
            if (m_tkn) m_tc++;
        end

        @(posedge clk);
        #1;
        check_val("resolved_a", {31'b0, res_a}, {31'b0, m_res});
        check_val("taken_a",    {31'b0, tkn_a}, {31'b0, m_tkn});
        check_val("timeout_a",  {31'b0, to_a},  {31'b0, m_to});
        check_val("bcnt_a",     {16'b0, bc_a},  32'(sat(m_bc, 65535)));
        check_val("tcnt_a",     {16'b0, tc_a},  32'(sat(m_tc, 65535)));
        check_val("resolved_b", {31'b0, res_b}, {31'b0, m_res});
        check_val("taken_b",    {31'b0, tkn_b}, {31'b0, m_tkn});
        check_val("timeout_b",  {31'b0, to_b},  {31'b0, m_to});
        check_val("bcnt_b",     {30'b0, bc_b},  32'(sat(m_bc, 3)));
        check_val("tcnt_b",     {30'b0, tc_b},  32'(sat(m_tc, 3)));
    endtask

    task automatic idle1();
        cycle(0, 0, 3'd0, 32'd0, 32'd0, 0, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        cycle(1, 0, 3'd0, 32'd0, 32'd0, 0, 0);

        // Equal/not-equal on identical data
        cycle(0, 1, 3'd0, 32'h0000_1234, 32'h0000_1234, 0, 0);
        check_val("eq_bcnt_const", {16'b0, bc_a}, 32'd1);
        cycle(0, 1, 3'd1, 32'h0000_1234, 32'h0000_1234, 0, 0);
        check_val("ne_taken_const", {31'b0, tkn_a}, 32'd0);
        check_val("ne_tcnt_const",  {16'b0, tc_a},  32'd1);

        // Signed vs unsigned boundary, plus illegal mode
        cycle(0, 1, 3'd2, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
        check_val("lt_taken_const", {31'b0, tkn_a}, 32'd1);
        cycle(0, 1, 3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
        cycle(0, 1, 3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
        cycle(0, 1, 3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
        check_val("ill_res_const", {31'b0, res_a}, 32'd1);
        idle1();

        // Two pending cycles then operands arrive
        cycle(0, 1, 3'd0, 32'h55, 32'h55, 1, 0);
        cycle(0, 1, 3'd0, 32'h55, 32'h55, 1, 0);
        cycle(0, 1, 3'd0, 32'h55, 32'h55, 0, 0);
        check_val("pend_res_const", {31'b0, res_a}, 32'd1);
        idle1();

        // Timeout: pending held for longer than the wait budget
        for (int i = 0; i < MAX_WAIT + 2; i++) cycle(0, 1, 3'd0, 32'h1, 32'h1, 1, 0);
        check_val("to_const", {31'b0, to_a}, 32'd1);
        idle1();

        // Kill in second WAIT cycle as pending drops
        cycle(0, 1, 3'd0, 32'h7, 32'h7, 1, 0);
        cycle(0, 1, 3'd0, 32'h7, 32'h7, 1, 0);
        cycle(0, 1, 3'd0, 32'h7, 32'h7, 0, 1);
        idle1();

        // Reset mid-WAIT
        cycle(0, 1, 3'd0, 32'h7, 32'h7, 1, 0);
        cycle(1, 1, 3'd0, 32'h7, 32'h7, 1, 0);
        check_val("rst_to_const", {31'b0, to_a}, 32'd0);

        // Saturation on the narrow-counter instance
        for (int i = 0; i < 5; i++) cycle(0, 1, 3'd0, 32'h9, 32'h9, 0, 0);
        check_val("sat_bcnt_const", {30'b0, bc_b}, 32'd3);
        check_val("sat_tcnt_const", {30'b0, tc_b}, 32'd3);
        idle1();

        // Random traffic; operands biased toward equality and sign boundaries
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, b;
            bit r, v, p, k;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = ~a;
                2: b = a ^ 32'h8000_0000;
                default: b = $urandom;
            endcase
            r = ($urandom_range(0, 249) == 0);
            v = ($urandom_range(0, 3) != 0);
            p = ($urandom_range(0, 2) == 0);
            k = ($urandom_range(0, 9) == 0);
            cycle(r, v, 3'($urandom_range(0, 7)), a, b, p, k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution unit for the ID stage of the pipelined CPU. It generalises the single equality compare to six compare modes over a configurable data width. It waits with a bounded timeout when the forwarding path flags an operand as not yet available. It registers a one-cycle resolve/taken result for PC select and IF/ID flush, and keeps saturating branch statistics counters.

## Interface
- WIDTH, 32, operand width in bits
- CNT_W, 16, width of each statistics counter
- MAX_WAIT, 4, maximum cycles spent in WAIT before timeout (≥1)

- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  branch instruction present in ID
- mode_i  in  3  compare mode: 000 EQ, 001 NE, 010 LT signed, 011 GE signed, 100 LTU, 101 GEU, 110/111 illegal
- data1_i  in  WIDTH  rs operand (post-forwarding)
- data2_i  in  WIDTH  rt operand (post-forwarding)
- pending_i  in  1  an operand is still in flight (load-use); data not valid
- kill_i  in  1  cancel the current branch (exception or flush from a later stage)
- stall_o  out  1  hold PC and IF/ID (combinational)
- resolved_o  out  1  registered one-cycle pulse: branch resolved
- taken_o  out  1  registered: branch taken; only meaningful while resolved_o=1, else 0
- timeout_o  out  1  sticky: a WAIT exceeded MAX_WAIT
- branch_cnt_o  out  CNT_W  resolved branches, saturating
- taken_cnt_o  out  CNT_W  taken branches, saturating

## Operation
- Reset: state IDLE, wait_cnt=0, resolved_o=0, taken_o=0, timeout_o=0, both counters 0. stall_o then follows its equation.
- Compare: signed modes use WIDTH-bit two's complement; unsigned modes use plain magnitude. Illegal modes evaluate to not taken but still resolve and still count.
- A resolve event occurs at an edge:
  - in IDLE with valid_i=1, pending_i=0, kill_i=0; or
  - in WAIT with valid_i=1, pending_i=0, kill_i=0.
- Effect of a resolve event: the mode result is computed from inputs sampled at that edge; resolved_o<=1; taken_o<=result; branch_cnt++; taken_cnt++ if taken.
- At every other edge: resolved_o<=0, taken_o<=0.
- States:
  - IDLE:
    - valid_i&pending_i&!kill_i -> WAIT, wait_cnt<=0.
    - Otherwise stay in IDLE; a resolve event may occur.
  - WAIT:
    - kill_i or !valid_i -> IDLE, no resolve, no count.
    - !pending_i -> resolve event, -> IDLE.
    - pending_i and wait_cnt==MAX_WAIT-1 -> IDLE, timeout_o<=1, no resolve.
    - Otherwise wait_cnt++.
- stall_o = (state==WAIT & !kill_i) | (state==IDLE & valid_i & pending_i & !kill_i).
- kill_i has priority over resolve and over timeout in the same cycle.
- Counters saturate at all-ones and never wrap; taken_cnt_o ≤ branch_cnt_o always.
- timeout_o clears only on rst_i.
- Reset mid-WAIT: return to IDLE and clear all state and outputs at that edge. No resolve.

## Timing
- Latency: a branch accepted in cycle N with operands ready gives resolved_o/taken_o high in cycle N+1, for exactly one cycle.
- Back-to-back resolvable branches in IDLE give resolved_o high on consecutive cycles.
- Pending case: stall_o is high from the cycle pending is first seen until the cycle pending_i falls (inclusive). resolved_o is high the cycle after that.
- Maximum stall length: 1+MAX_WAIT cycles, after which stall_o drops with timeout_o=1.
- Counters are visible the cycle after the resolve edge, aligned with resolved_o.

## Test plan
- EQ, data1=data2=0x0000_1234, pending=0 -> next cycle resolved_o=1, taken_o=1, branch_cnt=1, taken_cnt=1. Then NE on the same data -> resolved_o=1, taken_o=0, branch_cnt=2, taken_cnt=1.
- data1=0xFFFF_FFFF, data2=0x0000_0001:
  - LT -> taken=1; LTU -> taken=0; GEU -> taken=1.
  - mode 111 -> resolved=1, taken=0, counted.
- valid with pending_i high for 2 cycles, then low, data equal, EQ -> stall_o high for 3 cycles; resolved_o=1, taken_o=1 on the 4th.
- MAX_WAIT=4, pending held high -> stall_o high for 5 cycles, then 0; timeout_o=1 and stays 1; resolved_o never asserted.
- kill_i in the 2nd WAIT cycle with pending dropping that same cycle -> no resolve, counters unchanged, stall_o=0 that cycle. Separately, rst_i mid-WAIT -> all outputs 0 next cycle.
- CNT_W=2, 5 taken EQ branches back-to-back -> resolved_o high 5 consecutive cycles; both counters end at 3 (saturated), no wrap.
